// File: rtl/xif_result_pkg.sv
// Shared types and widths for the CV-X-IF result arbiter.
// The entry layout {id, data, rd, we, exc} is used by the FIFOs and the output mux.
package xif_result_pkg;

    localparam int RD_WIDTH       = 5;
    localparam int ID_WIDTH_DEF   = 4;
    localparam int DATA_WIDTH_DEF = 32;

    typedef struct packed {
        logic [ID_WIDTH_DEF-1:0]   id;
        logic [DATA_WIDTH_DEF-1:0] data;
        logic [RD_WIDTH-1:0]       rd;
        logic                      we;
        logic                      exc;
    } result_entry_t;

    typedef enum logic [0:0] {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width of one flattened entry for arbitrary id/data widths.
    function automatic int entry_width(input int id_w, input int data_w);
        return id_w + data_w + RD_WIDTH + 2;
    endfunction

endpackage

// File: rtl/xif_result_fifo.sv
// Per-channel result FIFO: DEPTH entries (any value >= 1), count-based full/empty,
// no bypass, flush has priority over push and pop.
module xif_result_fifo
    import xif_result_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 43,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int KW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [KW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [KW-1:0]    cnt_q, cnt_d;
    logic             push_s, pop_s;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    assign push_s  = push_i & ~full_o & ~flush_i;
    assign pop_s   = pop_i & ~empty_o & ~flush_i;
    assign full_o  = (cnt_q == KW'(DEPTH));
    assign empty_o = (cnt_q == {KW{1'b0}});
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = {PW{1'b0}};
            rd_d  = {PW{1'b0}};
            cnt_d = {KW{1'b0}};
        end else begin
            if (push_s) begin
                wr_d = ptr_inc(wr_q);
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = ptr_inc(rd_q);
            end else begin
                rd_d = rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + KW'(1'b1);
                2'b01:   cnt_d = cnt_q - KW'(1'b1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= {PW{1'b0}};
            rd_q  <= {PW{1'b0}};
            cnt_q <= {KW{1'b0}};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/xif_result_arbiter.sv
// Merges N_CH coprocessor X-IF result streams onto one core result port through
// per-channel FIFOs and a round-robin arbiter whose grant locks until the handshake.
module xif_result_arbiter
    import xif_result_pkg::*;
#(
    parameter  int N_CH       = 2,
    parameter  int DEPTH      = 2,
    parameter  int ID_WIDTH   = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int CHW        = $clog2(N_CH) + 1,
    localparam int INW        = $clog2(N_CH * DEPTH + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [N_CH-1:0]              ch_valid_i,
    output logic [N_CH-1:0]              ch_ready_o,
    input  logic [N_CH*ID_WIDTH-1:0]     ch_id_i,
    input  logic [N_CH*DATA_WIDTH-1:0]   ch_data_i,
    input  logic [N_CH*RD_WIDTH-1:0]     ch_rd_i,
    input  logic [N_CH-1:0]              ch_we_i,
    input  logic [N_CH-1:0]              ch_exc_i,
    output logic                         x_result_valid_o,
    input  logic                         x_result_ready_i,
    output logic [ID_WIDTH-1:0]          x_result_id_o,
    output logic [DATA_WIDTH-1:0]        x_result_data_o,
    output logic [RD_WIDTH-1:0]          x_result_rd_o,
    output logic                         x_result_we_o,
    output logic                         x_result_exc_o,
    output logic [CHW-1:0]               x_result_ch_o,
    output logic [INW-1:0]               inflight_o
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int EW = entry_width(ID_WIDTH, DATA_WIDTH);
    localparam int KW = $clog2(DEPTH + 1);

    logic [EW-1:0]   entry_s [N_CH];
    logic [EW-1:0]   head_s  [N_CH];
    logic [KW-1:0]   count_s [N_CH];
    logic [N_CH-1:0] full_s, empty_s, push_s, pop_s;

    arb_state_t      state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d, rr_q, rr_d, gnt_s, search_s;
    logic            valid_s, hs_s, found_s;
    logic [EW-1:0]   out_s;
    logic [INW-1:0]  inflight_q, inflight_d;

    function automatic logic [GW-1:0] next_ch(input logic [GW-1:0] g);
        if (g == GW'(N_CH - 1)) begin
            return {GW{1'b0}};
        end else begin
            return g + GW'(1'b1);
        end
    endfunction

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign entry_s[c] = {ch_id_i[c*ID_WIDTH +: ID_WIDTH],
                             ch_data_i[c*DATA_WIDTH +: DATA_WIDTH],
                             ch_rd_i[c*RD_WIDTH +: RD_WIDTH],
                             ch_we_i[c], ch_exc_i[c]};
        assign push_s[c]  = ch_valid_i[c] & ~full_s[c] & ~flush_i;
        assign pop_s[c]   = hs_s & (gnt_s == GW'(c)) & ~flush_i;

        xif_result_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (push_s[c]),
            .data_i  (entry_s[c]),
            .pop_i   (pop_s[c]),
            .head_o  (head_s[c]),
            .full_o  (full_s[c]),
            .empty_o (empty_s[c]),
            .count_o (count_s[c])
        );
    end

    // Ready depends only on FIFO state, never on the core's ready.
    assign ch_ready_o = ~full_s;
    assign valid_s    = |(~empty_s);
    assign hs_s       = valid_s & x_result_ready_i;

    // First non-empty channel at or after the round-robin pointer.
    always_comb begin
        int idx;
        search_s = rr_q;
        found_s  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr_q) + i) % N_CH;
            if (!found_s && !empty_s[idx]) begin
                search_s = GW'(idx);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant/lock next state: the grant freezes while valid waits for ready.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_LOCKED: gnt_s = gnt_q;
            default:    gnt_s = search_s;
        endcase
        if (flush_i) begin
            state_d = ARB_OPEN;
            gnt_d   = {GW{1'b0}};
            rr_d    = {GW{1'b0}};
        end else if (hs_s) begin
            state_d = ARB_OPEN;
            gnt_d   = gnt_s;
            rr_d    = next_ch(gnt_s);
        end else if (valid_s) begin
            state_d = ARB_LOCKED;
            gnt_d   = gnt_s;
        end else begin
            state_d = state_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_OPEN;
            gnt_q   <= {GW{1'b0}};
            rr_q    <= {GW{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    // Payload is forced to zero whenever nothing is presented.
    always_comb begin
        out_s = {EW{1'b0}};
        if (valid_s) begin
            out_s = head_s[gnt_s];
        end else begin
            out_s = {EW{1'b0}};
        end
    end

    assign x_result_valid_o = valid_s;
    assign {x_result_id_o, x_result_data_o, x_result_rd_o,
            x_result_we_o, x_result_exc_o} = out_s;
    assign x_result_ch_o    = valid_s ? CHW'(gnt_s) : {CHW{1'b0}};

    // Next occupancy: current counts plus this cycle's accepted pushes minus pops.
    always_comb begin
        inflight_d = {INW{1'b0}};
        if (flush_i) begin
            inflight_d = {INW{1'b0}};
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                inflight_d = inflight_d + INW'(count_s[c]) + INW'(push_s[c]) - INW'(pop_s[c]);
            end
        end
    end

    // Registered total occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= {INW{1'b0}};
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight_o = inflight_q;

endmodule
